// File: rtl/stream_decipher_rx.sv
// stream_decipher_rx
//   Decrypts a byte stream by XOR with an 8-bit Fibonacci LFSR keystream.
//   The keystream is seeded by seed_load. There is one registered output
//   slot with a valid/ready handshake on both the input and output sides.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   seed_load  loads seed into the keystream (seed 0 becomes 1); discards pending output
//   seed[7:0]  keystream seed
//   in_valid   ciphertext byte offered
//   in_data    ciphertext byte
//   in_ready   byte accepted this cycle when in_valid is also high
//   out_valid  out_data holds a decrypted byte
//   out_data   plaintext byte (registered)
//   out_ready  consumer takes out_data when out_valid is also high
//   byte_count bytes accepted since the last seed load or reset (wraps at 256)
//   keyed      a seed has been loaded since reset
module stream_decipher_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       seed_load,
  input  logic [7:0] seed,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic [7:0] byte_count,
  output logic       keyed
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] ks;
  logic       accept;
  logic       take;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // The output slot is full exactly when the FSM is in HOLD.
  always_comb begin
    out_valid = (state == HOLD);
    keyed     = (state != IDLE);
    in_ready  = (state != IDLE) && !seed_load && (!out_valid || out_ready);
    accept    = in_valid && in_ready;
    take      = out_valid && out_ready;

    state_nxt = state;
    if (seed_load) begin
      state_nxt = RUN;
    end else begin
      unique case (state)
        IDLE:    state_nxt = IDLE;
        RUN:     if (accept) state_nxt = HOLD;
        HOLD:    if (take && !accept) state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ks         <= 8'h01;
      out_data   <= '0;
      byte_count <= '0;
    end else begin
      state <= state_nxt;
      if (seed_load) begin
        ks         <= (seed == 8'h00) ? 8'h01 : seed;
        byte_count <= '0;
      end else if (accept) begin
        out_data   <= in_data ^ ks;
        ks         <= lfsr_next(ks);
        byte_count <= byte_count + 8'd1;
      end
    end
  end

endmodule

// File: doc/stream_decipher_rx.md
STREAM_DECIPHER_RX -- requirements
Module: stream_decipher_rx

Interface
REQ-001 The module SHALL have one clock and a reset that is synchronous and active-high; the ports SHALL be named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 seed_load  input  1  on a rising edge while high, loads seed into the keystream generator.
REQ-005 seed  input  8  keystream seed, sampled only when seed_load=1.
REQ-006 in_valid  input  1  ciphertext byte on in_data is offered.
REQ-007 in_data  input  8  ciphertext byte.
REQ-008 in_ready  output  1  module accepts in_data this cycle; a byte transfers when in_valid=1 and in_ready=1.
REQ-009 out_valid  output  1  out_data holds a decrypted byte.
REQ-010 out_data  output  8  plaintext byte, registered.
REQ-011 out_ready  input  1  consumer takes out_data when out_valid=1 and out_ready=1.
REQ-012 byte_count  output  8  number of bytes accepted since the last seed load or reset, wrapping modulo 256.
REQ-013 keyed  output  1  high when a seed has been loaded since reset (state != IDLE).

Function
REQ-014 The keystream register ks SHALL be an 8-bit Fibonacci LFSR with next = {ks[6:0], ks[7]^ks[5]^ks[4]^ks[3]}.
REQ-015 On seed_load, ks SHALL become seed, except that seed=8'h00 SHALL load 8'h01 (lock-up avoidance).
REQ-016 The state machine SHALL have three states: IDLE (no key), RUN (output register empty), HOLD (output register full).
REQ-017 Transitions: IDLE->RUN on seed_load; RUN->HOLD on accepted byte; HOLD->RUN on output taken with no new accept; HOLD->HOLD on output taken with a simultaneous accept, or when out_ready=0; any state->RUN on seed_load.
REQ-018 in_ready SHALL be 1 iff state != IDLE, seed_load=0, and (out_valid=0 or out_ready=1).
REQ-019 On an accepted byte: out_data <= in_data XOR ks; out_valid <= 1; ks <= next(ks); byte_count <= byte_count+1, with 8'hFF wrapping to 8'h00.
REQ-020 Latency SHALL be one cycle from acceptance to out_valid=1; with out_ready held at 1, throughput SHALL be one byte per cycle.
REQ-021 While out_valid=1 and out_ready=0, out_data, ks and byte_count SHALL hold steady.
REQ-022 If the output is taken and no byte is accepted in the same cycle, out_valid SHALL go to 0 on the next cycle and out_data SHALL keep its last value.
REQ-023 seed_load SHALL take priority over everything else except rst: out_valid <= 0 (any pending byte is discarded), byte_count <= 0, ks reloaded, and a byte offered in that cycle is not accepted.
REQ-024 In IDLE, in_valid SHALL be ignored and ks SHALL NOT advance.
REQ-025 Encrypting a plaintext stream with the same seed and LFSR and feeding the result through this block SHALL reproduce the plaintext exactly.

Reset
REQ-026 While rst=1 at a clock edge, the following SHALL take these values: state=IDLE, ks=8'h01, out_valid=0, out_data=8'h00, byte_count=8'h00, keyed=0, and therefore in_ready=0.
REQ-027 rst SHALL take priority over seed_load and any handshake in the same cycle.
REQ-028 When rst is asserted mid-stream, any pending output SHALL be discarded.
REQ-029 After reset, a new seed_load SHALL be required before any byte is accepted.

Verification
REQ-030 Reset, then idle with in_valid=1 and in_data=8'h55 -> in_ready=0, out_valid=0, out_data=8'h00, byte_count=0, keyed=0.
REQ-031 seed=8'hAA loaded, then in_data 8'hCC and 8'h33 on back-to-back cycles with out_ready=1 -> out_data 8'h66 then 8'h66 (keys 8'hAA, 8'h55), byte_count=2.
REQ-032 seed=8'h00 loaded, then in_data 8'h01 and 8'h02 -> out_data 8'h00 and 8'h00 (keys 8'h01, 8'h02).
REQ-033 Backpressure: out_ready=0 after the first byte -> in_ready=0 and out_data stable for 5 cycles; after out_ready=1, the next byte is accepted with no byte lost or duplicated.
REQ-034 seed_load=1 while out_valid=1 and in_valid=1 -> next cycle out_valid=0, byte_count=0, and the offered byte is not consumed.
REQ-035 Accept 256 bytes, then assert rst mid-transfer -> byte_count wraps to 8'h00 after the 256th byte, and rst returns all outputs to their reset values (REQ-026).
